rom_download_router: RTL and testbench
======================================

Name: rom_download_router

Overview:
- Sits between the hps_io ioctl download stream and the williams2 core's ROM stores.
- Captures each downloaded byte in a one-deep holding register and decodes the byte into one of three regions: main CPU, sound CPU or graphics.
- Presents the byte to the selected store with a valid/ack handshake, back-pressuring hps_io through ioctl_wait.
- Holds the core in reset while a load is in progress and reports completion and size/overrun errors.

Parameters:
- ADDR_W, 17: width of ioctl_addr and of the region-relative output address.
- ROM_INDEX, 0: ioctl_index value that selects this router; downloads with any other index are ignored.
- SND_BASE, 17'h0C000: first address of the sound region; the main region is 0 to SND_BASE-1.
- GFX_BASE, 17'h10000: first address of the graphics region.
- TOTAL_SIZE, 17'h1C000: expected byte count of a complete load; the graphics region ends at TOTAL_SIZE-1.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download window from hps_io.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  ADDR_W  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to hps_io.
- rom_req  out  1  holding register valid; a byte is offered to a store.
- rom_sel  out  3  one-hot store select: bit0 main, bit1 sound, bit2 gfx.
- rom_addr  out  ADDR_W  address relative to the selected region's base.
- rom_data  out  8  byte for the store.
- rom_ack  in  1  the selected store accepts the byte this cycle.
- core_reset_n  out  1  active-low reset to williams2.
- rom_ready  out  1  last load completed cleanly.
- size_err  out  1  sticky; wrong byte count or out-of-range address.
- overrun_err  out  1  sticky; ioctl_wr arrived while the holding register was full and could not drain.

Behaviour:
- Reset values: ioctl_wait=0, rom_req=0, rom_sel=0, rom_addr=0, rom_data=0, core_reset_n=0, rom_ready=0, size_err=0, overrun_err=0, byte count=0, state=IDLE.
- Reset is asynchronous. Asserting it during a load aborts the load immediately, with no drain and no flags kept.
- States:
  - IDLE: core_reset_n=1 only if rom_ready=1, otherwise 0.
  - LOAD
  - DRAIN
  - DONE: core_reset_n=1.
- Active index: ioctl_index == ROM_INDEX. An active download is ioctl_download=1 with the active index.
- IDLE or DONE -> LOAD on the first cycle of an active download. Entry clears rom_ready, size_err, overrun_err and the byte count, and drives core_reset_n=0. A new download from DONE restarts this way.
- LOAD, byte capture when ioctl_wr=1 and the index is active:
  - If ioctl_addr >= TOTAL_SIZE: byte dropped, size_err set, count not incremented.
  - Else if the holding register is empty, or rom_ack=1 in the same cycle (pass-through): on the next edge rom_data=ioctl_dout, rom_addr=ioctl_addr-base, rom_sel=one-hot region, rom_req=1, count+1. Latency is one cycle from ioctl_wr to rom_req.
  - Else: byte dropped, overrun_err set.
- Region decode: addr < SND_BASE -> main, base 0; addr < GFX_BASE -> sound, base SND_BASE; otherwise gfx, base GFX_BASE.
- Handshake:
  - rom_req/rom_sel/rom_addr/rom_data stay stable while rom_req=1 and rom_ack=0.
  - rom_ack is ignored when rom_req=0.
  - rom_ack without a new byte clears rom_req and sets rom_sel=0 on the next edge.
- ioctl_wait = rom_req & ~rom_ack (combinational).
- LOAD -> DRAIN when ioctl_download falls. A byte strobed in that same cycle is still captured.
- DRAIN -> DONE on the cycle rom_req is 0, or on the edge where rom_ack completes the last byte. Entering DONE:
  - if count != TOTAL_SIZE, size_err is set;
  - rom_ready = ~size_err & ~overrun_err, from the updated values.
- The count is ADDR_W+1 bits and saturates at all-ones.
- ioctl_wr outside LOAD, or with an inactive index, is ignored in every state.

Test Plan:
- Clean load: TOTAL_SIZE bytes, data = addr[7:0], rom_ack tied 1 -> every byte appears one cycle later with correct sel/relative address; addr 17'h0C000 gives sel=3'b010, rom_addr=0; addr 17'h10005 gives sel=3'b100, rom_addr=5; rom_ready=1, core_reset_n=1, both error flags 0.
- Back-pressure: rom_ack held 0 for 4 cycles after the first byte (ioctl_addr=0, data 8'hA5) -> ioctl_wait=1 for those 4 cycles; rom_data stays 8'hA5 and rom_addr stays 0 throughout; byte is consumed on ack; ioctl_wait drops the same cycle.
- Pass-through: ioctl_wr and rom_ack in the same cycle at addr 1 then 2 -> rom_req stays 1 continuously and addresses step 1, 2 with no bubble.
- Overrun: second ioctl_wr while full and rom_ack=0 -> byte dropped, overrun_err=1; after a complete download rom_ready=0.
- Short load and out of range: stop after 16'h8000 bytes -> size_err=1, rom_ready=0; separately, a byte at 17'h1C000 -> dropped, size_err=1.
- Reset mid-LOAD and wrong index: pull reset_n low at byte 100 -> all outputs return to reset values immediately. A download with ioctl_index=1 -> no rom_req, state stays IDLE.

Source files
------------

// File: rtl/rom_download_router.sv
// Routes the hps_io ioctl download stream into the williams2 ROM stores
// (main CPU, sound CPU, graphics) through a one-deep valid/ack holding register.
module rom_download_router #(
  parameter int               ADDR_W     = 17,
  parameter logic [7:0]       ROM_INDEX  = 8'd0,
  parameter logic [ADDR_W-1:0] SND_BASE   = 17'h0C000,
  parameter logic [ADDR_W-1:0] GFX_BASE   = 17'h10000,
  parameter logic [ADDR_W-1:0] TOTAL_SIZE = 17'h1C000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              rom_req,
  output logic [2:0]        rom_sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  input  logic              rom_ack,
  output logic              core_reset_n,
  output logic              rom_ready,
  output logic              size_err,
  output logic              overrun_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_TOTAL = {1'b0, TOTAL_SIZE};

  logic [1:0]        state_reg, state_next;
  logic              req_reg, req_next;
  logic [2:0]        sel_reg, sel_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              ready_reg, ready_next;
  logic              size_err_reg, size_err_next;
  logic              ovr_err_reg, ovr_err_next;

  logic              index_active;
  logic              wr_active;
  logic              in_range;
  logic              can_take;
  logic              take;
  logic              size_short;
  logic [2:0]        dec_sel;
  logic [ADDR_W-1:0] dec_base;

  assign index_active = (ioctl_index == ROM_INDEX);
  assign wr_active    = ioctl_wr & index_active & (state_reg == ST_LOAD);
  assign in_range     = (ioctl_addr < TOTAL_SIZE);
  // An ack in the same cycle frees the holding register, so a new byte can pass straight through.
  assign can_take     = ~req_reg | rom_ack;
  assign take         = wr_active & in_range & can_take;
  assign size_short   = (cnt_reg != CNT_TOTAL);

  always_comb begin
    dec_sel  = 3'b100;
    dec_base = GFX_BASE;
    if (ioctl_addr < SND_BASE) begin
      dec_sel  = 3'b001;
      dec_base = '0;
    end else if (ioctl_addr < GFX_BASE) begin
      dec_sel  = 3'b010;
      dec_base = SND_BASE;
    end
  end

  always_comb begin
    state_next    = state_reg;
    req_next      = req_reg;
    sel_next      = sel_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    cnt_next      = cnt_reg;
    ready_next    = ready_reg;
    size_err_next = size_err_reg;
    ovr_err_next  = ovr_err_reg;

    if (req_reg && rom_ack) begin
      req_next = 1'b0;
      sel_next = 3'b000;
    end

    if (take) begin
      req_next  = 1'b1;
      sel_next  = dec_sel;
      addr_next = ioctl_addr - dec_base;
      data_next = ioctl_dout;
      cnt_next  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    end

    if (wr_active && !in_range)
      size_err_next = 1'b1;
    if (wr_active && in_range && !can_take)
      ovr_err_next = 1'b1;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (ioctl_download && index_active) begin
          state_next    = ST_LOAD;
          ready_next    = 1'b0;
          size_err_next = 1'b0;
          ovr_err_next  = 1'b0;
          cnt_next      = '0;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download)
          state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // No captures happen here, so cnt_reg is already the final byte count.
        if (!req_reg || rom_ack) begin
          state_next    = ST_DONE;
          size_err_next = size_err_reg | size_short;
          ready_next    = ~(size_err_reg | size_short) & ~ovr_err_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      req_reg      <= 1'b0;
      sel_reg      <= 3'b000;
      addr_reg     <= '0;
      data_reg     <= 8'h00;
      cnt_reg      <= '0;
      ready_reg    <= 1'b0;
      size_err_reg <= 1'b0;
      ovr_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      req_reg      <= req_next;
      sel_reg      <= sel_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      cnt_reg      <= cnt_next;
      ready_reg    <= ready_next;
      size_err_reg <= size_err_next;
      ovr_err_reg  <= ovr_err_next;
    end
  end

  assign ioctl_wait   = req_reg & ~rom_ack;
  assign rom_req      = req_reg;
  assign rom_sel      = sel_reg;
  assign rom_addr     = addr_reg;
  assign rom_data     = data_reg;
  assign rom_ready    = ready_reg;
  assign size_err     = size_err_reg;
  assign overrun_err  = ovr_err_reg;
  assign core_reset_n = (state_reg == ST_DONE) | ((state_reg == ST_IDLE) & ready_reg);

endmodule

// File: tb/tb_rom_download_router.sv
// Randomized bench for rom_download_router, scaled-down region map, checked
// against a queue-based model of the bytes each store should receive.
module tb_rom_download_router;

  localparam logic [16:0] TB_SND   = 17'h000C0;
  localparam logic [16:0] TB_GFX   = 17'h00100;
  localparam logic [16:0] TB_TOTAL = 17'h001C0;
  localparam logic [7:0]  TB_INDEX = 8'd0;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [16:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        rom_ack = 1'b0;
  logic        ioctl_wait, rom_req, core_reset_n, rom_ready, size_err, overrun_err;
  logic [2:0]  rom_sel;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;

  rom_download_router #(
    .ADDR_W(17), .ROM_INDEX(TB_INDEX), .SND_BASE(TB_SND),
    .GFX_BASE(TB_GFX), .TOTAL_SIZE(TB_TOTAL)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .rom_req(rom_req), .rom_sel(rom_sel),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ack(rom_ack),
    .core_reset_n(core_reset_n), .rom_ready(rom_ready),
    .size_err(size_err), .overrun_err(overrun_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [2:0]  sel;
    logic [16:0] addr;
    logic [7:0]  data;
  } xfer_t;

  xfer_t exp_q[$];
  int    m_phase;   // 0 idle, 1 loading, 2 draining, 3 done
  int    m_cnt;
  bit    m_size_err, m_ovr_err, m_ready;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic xfer_t route(input logic [16:0] a, input logic [7:0] d);
    xfer_t t;
    t.data = d;
    if (a < TB_SND) begin
      t.sel = 3'b001; t.addr = a;
    end else if (a < TB_GFX) begin
      t.sel = 3'b010; t.addr = a - TB_SND;
    end else begin
      t.sel = 3'b100; t.addr = a - TB_GFX;
    end
    return t;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_phase = 0; m_cnt = 0;
    m_size_err = 0; m_ovr_err = 0; m_ready = 0;
  endtask

  // Compare the DUT against the model for the current cycle, then advance the model across the next edge.
  task automatic model_step();
    bit busy;
    bit exp_crn;
    busy = (exp_q.size() != 0);
    exp_crn = (m_phase == 3) || (m_phase == 0 && m_ready);
    check("rom_req", 32'(rom_req), 32'(busy));
    check("ioctl_wait", 32'(ioctl_wait), 32'(busy && !rom_ack));
    if (busy) begin
      check("rom_sel", 32'(rom_sel), 32'(exp_q[0].sel));
      check("rom_addr", 32'(rom_addr), 32'(exp_q[0].addr));
      check("rom_data", 32'(rom_data), 32'(exp_q[0].data));
    end
    check("size_err", 32'(size_err), 32'(m_size_err));
    check("overrun_err", 32'(overrun_err), 32'(m_ovr_err));
    check("rom_ready", 32'(rom_ready), 32'(m_ready));
    check("core_reset_n", 32'(core_reset_n), 32'(exp_crn));

    if (busy && rom_ack) begin
      $display("xfer sel=%b addr=%05h data=%02h", exp_q[0].sel, exp_q[0].addr, exp_q[0].data);
      void'(exp_q.pop_front());
    end
    case (m_phase)
      0, 3: begin
        if (ioctl_download && ioctl_index == TB_INDEX) begin
          m_phase = 1; m_cnt = 0;
          m_size_err = 0; m_ovr_err = 0; m_ready = 0;
        end
      end
      1: begin
        if (ioctl_wr && ioctl_index == TB_INDEX) begin
          if (ioctl_addr >= TB_TOTAL) m_size_err = 1;
          else if (!busy || rom_ack) begin
            exp_q.push_back(route(ioctl_addr, ioctl_dout));
            m_cnt++;
          end else m_ovr_err = 1;
        end
        if (!ioctl_download) m_phase = 2;
      end
      2: begin
        if (!busy || rom_ack) begin
          m_phase = 3;
          if (m_cnt != int'(TB_TOTAL)) m_size_err = 1;
          m_ready = !m_size_err && !m_ovr_err;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic drive(input bit dl, input logic [7:0] idx, input bit wr,
                       input logic [16:0] a, input logic [7:0] d, input bit ack);
    @(negedge clk_sys);
    ioctl_download = dl; ioctl_index = idx; ioctl_wr = wr;
    ioctl_addr = a; ioctl_dout = d; rom_ack = ack;
    #1;
    model_step();
  endtask

  task automatic start_download(input logic [7:0] idx);
    drive(1'b1, idx, 1'b0, '0, 8'h00, 1'b0);
  endtask

  // Sequential addresses first..last; rnd=0 means back-to-back strobes with ack tied high.
  task automatic load_seq(input int first, input int last, input bit rnd);
    int a, guard;
    bit ack, room, wr, prev_wr;
    logic [16:0] prev;
    logic [7:0] d;
    a = first; guard = 0; prev_wr = 0; prev = '0;
    while (a <= last && guard < 5000) begin
      ack  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      room = (exp_q.size() == 0) || ack;
      wr   = room && (!rnd || $urandom_range(0, 3) != 0);
      d    = rnd ? 8'($urandom) : 8'(a);
      drive(1'b1, TB_INDEX, wr, 17'(a), d, ack);
      if (!rnd && prev_wr && prev == TB_SND) begin
        check("snd_base_sel", 32'(rom_sel), 32'h2);
        check("snd_base_addr", 32'(rom_addr), 32'h0);
      end
      if (!rnd && prev_wr && prev == 17'(TB_GFX + 17'd5)) begin
        check("gfx_5_sel", 32'(rom_sel), 32'h4);
        check("gfx_5_addr", 32'(rom_addr), 32'h5);
      end
      prev = 17'(a); prev_wr = wr;
      if (wr) a++;
      guard++;
    end
    check("load_seq_budget", 32'(a), 32'(last + 1));
  endtask

  task automatic end_download();
    int g;
    drive(1'b0, TB_INDEX, 1'b0, '0, 8'h00, 1'b1);
    g = 0;
    while (m_phase != 3 && g < 16) begin
      drive(1'b0, TB_INDEX, 1'b0, '0, 8'h00, 1'b1);
      g++;
    end
    drive(1'b0, TB_INDEX, 1'b0, '0, 8'h00, 1'b0);
    check("done_core_reset_n", 32'(core_reset_n), 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(rom_req), 32'h0);
    check({tag, "_sel"}, 32'(rom_sel), 32'h0);
    check({tag, "_addr"}, 32'(rom_addr), 32'h0);
    check({tag, "_data"}, 32'(rom_data), 32'h0);
    check({tag, "_wait"}, 32'(ioctl_wait), 32'h0);
    check({tag, "_crn"}, 32'(core_reset_n), 32'h0);
    check({tag, "_ready"}, 32'(rom_ready), 32'h0);
    check({tag, "_size"}, 32'(size_err), 32'h0);
    check({tag, "_ovr"}, 32'(overrun_err), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk_sys);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Clean load, ack tied high
    start_download(TB_INDEX);
    load_seq(0, int'(TB_TOTAL) - 1, 1'b0);
    end_download();
    check("clean_ready", 32'(rom_ready), 32'h1);
    check("clean_size", 32'(size_err), 32'h0);
    check("clean_ovr", 32'(overrun_err), 32'h0);

    // Back-pressure then pass-through, rest randomized
    start_download(TB_INDEX);
    drive(1'b1, TB_INDEX, 1'b1, 17'd0, 8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, TB_INDEX, 1'b0, '0, 8'h00, 1'b0);
      check("bp_wait", 32'(ioctl_wait), 32'h1);
      check("bp_data", 32'(rom_data), 32'hA5);
      check("bp_addr", 32'(rom_addr), 32'h0);
    end
    drive(1'b1, TB_INDEX, 1'b1, 17'd1, 8'h01, 1'b1);
    check("bp_wait_drop", 32'(ioctl_wait), 32'h0);
    drive(1'b1, TB_INDEX, 1'b1, 17'd2, 8'h02, 1'b1);
    check("pt_req_1", 32'(rom_req), 32'h1);
    check("pt_addr_1", 32'(rom_addr), 32'h1);
    drive(1'b1, TB_INDEX, 1'b1, 17'd3, 8'h03, 1'b1);
    check("pt_req_2", 32'(rom_req), 32'h1);
    check("pt_addr_2", 32'(rom_addr), 32'h2);
    load_seq(4, int'(TB_TOTAL) - 1, 1'b1);
    end_download();
    check("bp_ready", 32'(rom_ready), 32'h1);

    // Overrun
    start_download(TB_INDEX);
    drive(1'b1, TB_INDEX, 1'b1, 17'd0, 8'h11, 1'b0);
    drive(1'b1, TB_INDEX, 1'b1, 17'd1, 8'h22, 1'b0);
    drive(1'b1, TB_INDEX, 1'b0, '0, 8'h00, 1'b0);
    check("ovr_flag", 32'(overrun_err), 32'h1);
    check("ovr_kept_data", 32'(rom_data), 32'h11);
    load_seq(1, int'(TB_TOTAL) - 1, 1'b1);
    end_download();
    check("ovr_ready", 32'(rom_ready), 32'h0);
    check("ovr_flag_end", 32'(overrun_err), 32'h1);

    // Short load
    start_download(TB_INDEX);
    load_seq(0, 32'h80 - 1, 1'b1);
    end_download();
    check("short_size", 32'(size_err), 32'h1);
    check("short_ready", 32'(rom_ready), 32'h0);

    // Out-of-range address
    start_download(TB_INDEX);
    drive(1'b1, TB_INDEX, 1'b1, TB_TOTAL, 8'h77, 1'b1);
    drive(1'b1, TB_INDEX, 1'b0, '0, 8'h00, 1'b1);
    check("oor_req", 32'(rom_req), 32'h0);
    check("oor_size", 32'(size_err), 32'h1);
    end_download();

    // Asynchronous reset mid-load at byte 100
    start_download(TB_INDEX);
    load_seq(0, 99, 1'b0);
    #2;
    reset_n = 1'b0;
    ioctl_download = 1'b0; ioctl_wr = 1'b0; rom_ack = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Wrong index, then a stray strobe outside LOAD
    start_download(8'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'd1, 1'b1, 17'(i), 8'(i), 1'b0);
      check("widx_req", 32'(rom_req), 32'h0);
    end
    drive(1'b0, 8'd1, 1'b0, '0, 8'h00, 1'b0);
    drive(1'b0, TB_INDEX, 1'b1, 17'd5, 8'h55, 1'b0);
    drive(1'b0, TB_INDEX, 1'b0, '0, 8'h00, 1'b0);
    check("idle_strobe_req", 32'(rom_req), 32'h0);
    check("widx_crn", 32'(core_reset_n), 32'h0);
    check("widx_ready", 32'(rom_ready), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
